// File: rtl/src_control_seq_if.sv
// Control bundle between the Mini SRC sequencer (master) and the datapath (slave).
interface src_control_seq_if;
    logic       run;
    logic [4:0] opcode;
    logic       con_ff;

    logic       incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_CON_FF;
    logic       ram_read, ram_write, MDR_read;
    logic       Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;
    logic [3:0] ALU_op;
    logic [4:0] BusDataSelect;
    logic       instr_done, halted, illegal;

    modport master (
        input  run, opcode, con_ff,
        output incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_CON_FF,
        output ram_read, ram_write, MDR_read,
        output Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel,
        output ALU_op, BusDataSelect, instr_done, halted, illegal
    );

    modport slave (
        output run, opcode, con_ff,
        input  incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_CON_FF,
        input  ram_read, ram_write, MDR_read,
        input  Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel,
        input  ALU_op, BusDataSelect, instr_done, halted, illegal
    );
endinterface

// File: rtl/src_control_seq.sv
// Hardwired fetch/decode/execute sequencer for the Mini SRC datapath, registered Moore outputs.
// Define SRC_SEQ_STEP_EN to add the single-step input and STEPWAIT parking state.
module src_control_seq #(
    parameter int unsigned MEM_LAT = 1,
    parameter logic [3:0]  ALU_ADD = 4'b0011,
    parameter logic [4:0]  SEL_PC  = 5'b10100,
    parameter logic [4:0]  SEL_MDR = 5'b10101,
    parameter logic [4:0]  SEL_ZLO = 5'b10011,
    parameter logic [4:0]  SEL_C   = 5'b11000
) (
    input logic clock,
    input logic clear,
`ifdef SRC_SEQ_STEP_EN
    input logic step,
`endif
    src_control_seq_if.master bus
);

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpBr   = 5'b10011;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;
    localparam logic [3:0] LatInit = 4'(MEM_LAT - 1);

    typedef enum logic [4:0] {
        StIdle, StF0, StF1, StF2, StF3, StDec,
        StLdiE0, StLdiE1, StLdiE2,
        StLdE0, StLdE1, StLdE2, StLdE3, StLdE4, StLdE5,
        StStE0, StStE1, StStE2, StStE3, StStE4,
        StAddE0, StAddE1, StAddE2,
        StBrE0, StBrE1, StBrE2, StBrE3,
        StNop, StHalted
`ifdef SRC_SEQ_STEP_EN
        , StStepWait
`endif
    } state_e;

    typedef struct packed {
        logic       incpc, e_pc, e_ir, e_y, e_z, e_mdr, e_mar, e_con_ff;
        logic       ram_read, ram_write, mdr_read;
        logic       gra, grb, grc, e_rin, e_rout, baout, imm_sel;
        logic [3:0] alu_op;
        logic [4:0] bus_sel;
        logic       instr_done, halted, illegal;
    } ctrl_t;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       instr_end;
`ifdef SRC_SEQ_STEP_EN
    logic       step_q;
`endif

    // The constant reaches the bus through imm_sel, so no state drives SEL_C.
    logic unused_params;
    assign unused_params = ^SEL_C;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ctrl_q  <= '0;
`ifdef SRC_SEQ_STEP_EN
            step_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
`ifdef SRC_SEQ_STEP_EN
            step_q  <= step;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        instr_end = 1'b0;
        unique case (state_q)
            StIdle:  if (bus.run) state_d = StF0;
            StF0:    begin state_d = StF1; cnt_d = LatInit; end
            StF1:    if (cnt_q == '0) state_d = StF2; else cnt_d = cnt_q - 4'd1;
            StF2:    state_d = StF3;
            StF3:    state_d = StDec;
            StDec: begin
                case (bus.opcode)
                    OpLd:    state_d = StLdE0;
                    OpLdi:   state_d = StLdiE0;
                    OpSt:    state_d = StStE0;
                    OpAdd:   state_d = StAddE0;
                    OpBr:    state_d = StBrE0;
                    OpHalt:  state_d = StHalted;
                    default: state_d = StNop;
                endcase
            end
            StLdiE0: state_d = StLdiE1;
            StLdiE1: state_d = StLdiE2;
            StLdE0:  state_d = StLdE1;
            StLdE1:  state_d = StLdE2;
            StLdE2:  begin state_d = StLdE3; cnt_d = LatInit; end
            StLdE3:  if (cnt_q == '0) state_d = StLdE4; else cnt_d = cnt_q - 4'd1;
            StLdE4:  state_d = StLdE5;
            StStE0:  state_d = StStE1;
            StStE1:  state_d = StStE2;
            StStE2:  state_d = StStE3;
            StStE3:  begin state_d = StStE4; cnt_d = LatInit; end
            StStE4:  if (cnt_q == '0) instr_end = 1'b1; else cnt_d = cnt_q - 4'd1;
            StAddE0: state_d = StAddE1;
            StAddE1: state_d = StAddE2;
            StBrE0:  state_d = StBrE1;
            StBrE1:  state_d = StBrE2;
            StBrE2:  state_d = StBrE3;
            StLdiE2, StLdE5, StAddE2, StBrE3, StNop: instr_end = 1'b1;
            StHalted: state_d = StHalted;
`ifdef SRC_SEQ_STEP_EN
            StStepWait: if (step && !step_q) state_d = bus.run ? StF0 : StIdle;
`endif
            default: state_d = StIdle;
        endcase
        if (instr_end) begin
`ifdef SRC_SEQ_STEP_EN
            state_d = StStepWait;
`else
            state_d = bus.run ? StF0 : StIdle;
`endif
        end
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            StF0: begin ctrl_d.bus_sel = SEL_PC; ctrl_d.e_mar = 1'b1; ctrl_d.incpc = 1'b1; end
            StF1, StLdE3: ctrl_d.ram_read = 1'b1;
            StF2, StLdE4: begin ctrl_d.mdr_read = 1'b1; ctrl_d.e_mdr = 1'b1; end
            StF3: begin ctrl_d.bus_sel = SEL_MDR; ctrl_d.e_ir = 1'b1; end
            StLdiE0, StLdE0, StStE0: begin
                ctrl_d.grb = 1'b1; ctrl_d.baout = 1'b1; ctrl_d.e_y = 1'b1;
            end
            StLdiE1, StLdE1, StStE1, StBrE2: begin
                ctrl_d.imm_sel = 1'b1; ctrl_d.alu_op = ALU_ADD; ctrl_d.e_z = 1'b1;
            end
            StLdiE2, StAddE2: begin
                ctrl_d.bus_sel = SEL_ZLO; ctrl_d.gra = 1'b1; ctrl_d.e_rin = 1'b1;
            end
            StLdE2, StStE2: begin ctrl_d.bus_sel = SEL_ZLO; ctrl_d.e_mar = 1'b1; end
            StLdE5: begin ctrl_d.bus_sel = SEL_MDR; ctrl_d.gra = 1'b1; ctrl_d.e_rin = 1'b1; end
            StStE3: begin ctrl_d.gra = 1'b1; ctrl_d.e_rout = 1'b1; ctrl_d.e_mdr = 1'b1; end
            StStE4: ctrl_d.ram_write = 1'b1;
            StAddE0: begin ctrl_d.grb = 1'b1; ctrl_d.e_rout = 1'b1; ctrl_d.e_y = 1'b1; end
            StAddE1: begin
                ctrl_d.grc = 1'b1; ctrl_d.e_rout = 1'b1;
                ctrl_d.alu_op = ALU_ADD; ctrl_d.e_z = 1'b1;
            end
            StBrE0: begin ctrl_d.gra = 1'b1; ctrl_d.e_rout = 1'b1; ctrl_d.e_con_ff = 1'b1; end
            StBrE1: begin ctrl_d.bus_sel = SEL_PC; ctrl_d.e_y = 1'b1; end
            StBrE3: begin ctrl_d.bus_sel = SEL_ZLO; ctrl_d.e_pc = bus.con_ff; end
            StHalted: ctrl_d.halted = 1'b1;
            default: ;
        endcase
        unique case (state_d)
            StLdiE2, StLdE5, StAddE2, StBrE3, StNop: ctrl_d.instr_done = 1'b1;
            StStE4:  ctrl_d.instr_done = (cnt_d == '0);
            default: ;
        endcase
        ctrl_d.illegal = (state_q == StDec) && (state_d == StNop) && (bus.opcode != OpNop);
    end

    assign bus.incPC         = ctrl_q.incpc;
    assign bus.e_PC          = ctrl_q.e_pc;
    assign bus.e_IR          = ctrl_q.e_ir;
    assign bus.e_Y           = ctrl_q.e_y;
    assign bus.e_Z           = ctrl_q.e_z;
    assign bus.e_MDR         = ctrl_q.e_mdr;
    assign bus.e_MAR         = ctrl_q.e_mar;
    assign bus.e_CON_FF      = ctrl_q.e_con_ff;
    assign bus.ram_read      = ctrl_q.ram_read;
    assign bus.ram_write     = ctrl_q.ram_write;
    assign bus.MDR_read      = ctrl_q.mdr_read;
    assign bus.Gra           = ctrl_q.gra;
    assign bus.Grb           = ctrl_q.grb;
    assign bus.Grc           = ctrl_q.grc;
    assign bus.e_Rin         = ctrl_q.e_rin;
    assign bus.e_Rout        = ctrl_q.e_rout;
    assign bus.BAout         = ctrl_q.baout;
    assign bus.imm_sel       = ctrl_q.imm_sel;
    assign bus.ALU_op        = ctrl_q.alu_op;
    assign bus.BusDataSelect = ctrl_q.bus_sel;
    assign bus.instr_done    = ctrl_q.instr_done;
    assign bus.halted        = ctrl_q.halted;
    assign bus.illegal       = ctrl_q.illegal;

endmodule

// File: tb/tb_src_control_seq.sv
// Self-checking bench for src_control_seq: spec-count table, random trace model, corner sequences.
module tb_src_control_seq;
    localparam int unsigned MemLat = 3;
    localparam int          L      = int'(MemLat);
    localparam logic [4:0]  SelPc  = 5'b10100;
    localparam logic [4:0]  SelMdr = 5'b10101;
    localparam logic [4:0]  SelZlo = 5'b10011;
    localparam logic [3:0]  AluAdd = 4'b0011;
    localparam logic [4:0]  OpLd = 5'b00000, OpLdi = 5'b00001, OpSt = 5'b00010;
    localparam logic [4:0]  OpAdd = 5'b00011, OpBr = 5'b10011, OpNop = 5'b11010;
    localparam logic [4:0]  OpHalt = 5'b11011, OpIll = 5'b11111;

    typedef struct packed {
        logic       incpc, e_pc, e_ir, e_y, e_z, e_mdr, e_mar, e_con;
        logic       rr, rw, mdr_rd;
        logic       gra, grb, grc, rin, rout, baout, imm;
        logic [3:0] alu;
        logic [4:0] bus;
        logic       done, halted, ill;
    } obs_t;

    typedef struct {
        logic [4:0] opc;
        logic       con;
        int         cycles, reads, writes, epc, ill;
    } vec_t;

    logic clock = 1'b0;
    logic clear;
`ifdef SRC_SEQ_STEP_EN
    logic step;
`endif
    always #5 clock = ~clock;

    src_control_seq_if sif ();

    src_control_seq #(.MEM_LAT(MemLat)) dut (
        .clock (clock),
        .clear (clear),
`ifdef SRC_SEQ_STEP_EN
        .step  (step),
`endif
        .bus   (sif)
    );

    int   errors = 0;
    int   checks = 0;
    obs_t trace[$];
    obs_t f0w, zw, haltw;
    vec_t vecs[9];

    function automatic obs_t sample();
        obs_t o;
        o.incpc = sif.incPC;   o.e_pc = sif.e_PC;     o.e_ir = sif.e_IR;   o.e_y = sif.e_Y;
        o.e_z = sif.e_Z;       o.e_mdr = sif.e_MDR;   o.e_mar = sif.e_MAR; o.e_con = sif.e_CON_FF;
        o.rr = sif.ram_read;   o.rw = sif.ram_write;  o.mdr_rd = sif.MDR_read;
        o.gra = sif.Gra;       o.grb = sif.Grb;       o.grc = sif.Grc;     o.rin = sif.e_Rin;
        o.rout = sif.e_Rout;   o.baout = sif.BAout;   o.imm = sif.imm_sel;
        o.alu = sif.ALU_op;    o.bus = sif.BusDataSelect;
        o.done = sif.instr_done; o.halted = sif.halted; o.ill = sif.illegal;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push(input obs_t o, input int n);
        for (int i = 0; i < n; i++) trace.push_back(o);
    endtask

    // Expected per-cycle control words of one instruction, listed T-state by T-state.
    task automatic build(input logic [4:0] opc, input logic con, output int dec_idx);
        obs_t o;
        int   last;
        trace.delete();
        push(f0w, 1);
        o = '0; o.rr = 1'b1; push(o, L);
        o = '0; o.mdr_rd = 1'b1; o.e_mdr = 1'b1; push(o, 1);
        o = '0; o.bus = SelMdr; o.e_ir = 1'b1; push(o, 1);
        dec_idx = trace.size();
        push(zw, 1);
        if (opc == OpLdi || opc == OpLd || opc == OpSt) begin
            o = '0; o.grb = 1'b1; o.baout = 1'b1; o.e_y = 1'b1; push(o, 1);
            o = '0; o.imm = 1'b1; o.alu = AluAdd; o.e_z = 1'b1; push(o, 1);
        end
        case (opc)
            OpLdi: begin o = '0; o.bus = SelZlo; o.gra = 1'b1; o.rin = 1'b1; push(o, 1); end
            OpLd: begin
                o = '0; o.bus = SelZlo; o.e_mar = 1'b1; push(o, 1);
                o = '0; o.rr = 1'b1; push(o, L);
                o = '0; o.mdr_rd = 1'b1; o.e_mdr = 1'b1; push(o, 1);
                o = '0; o.bus = SelMdr; o.gra = 1'b1; o.rin = 1'b1; push(o, 1);
            end
            OpSt: begin
                o = '0; o.bus = SelZlo; o.e_mar = 1'b1; push(o, 1);
                o = '0; o.gra = 1'b1; o.rout = 1'b1; o.e_mdr = 1'b1; push(o, 1);
                o = '0; o.rw = 1'b1; push(o, L);
            end
            OpAdd: begin
                o = '0; o.grb = 1'b1; o.rout = 1'b1; o.e_y = 1'b1; push(o, 1);
                o = '0; o.grc = 1'b1; o.rout = 1'b1; o.alu = AluAdd; o.e_z = 1'b1; push(o, 1);
                o = '0; o.bus = SelZlo; o.gra = 1'b1; o.rin = 1'b1; push(o, 1);
            end
            OpBr: begin
                o = '0; o.gra = 1'b1; o.rout = 1'b1; o.e_con = 1'b1; push(o, 1);
                o = '0; o.bus = SelPc; o.e_y = 1'b1; push(o, 1);
                o = '0; o.imm = 1'b1; o.alu = AluAdd; o.e_z = 1'b1; push(o, 1);
                o = '0; o.bus = SelZlo; o.e_pc = con; push(o, 1);
            end
            default: begin o = '0; o.ill = (opc != OpNop); push(o, 1); end
        endcase
        last = trace.size() - 1;
        o = trace[last];
        o.done = 1'b1;
        trace[last] = o;
    endtask

    // Runs one instruction from its F0 cycle through instr_done, counting strobe cycles.
    task automatic run_instr(input logic [4:0] opc, input logic con, output int cyc,
                             output int rd, output int wr, output int epc, output int ill,
                             output int inc);
        bit got;
        sif.opcode = opc;
        sif.con_ff = con;
        cyc = 0; rd = 0; wr = 0; epc = 0; ill = 0; inc = 0; got = 1'b0;
        while (!got && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
            rd  += int'(sif.ram_read);
            wr  += int'(sif.ram_write);
            epc += int'(sif.e_PC);
            ill += int'(sif.illegal);
            inc += int'(sif.incPC);
            got = sif.instr_done;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL instr_done timeout op=%b: got none required pulse", opc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int         cyc, rd, wr, epc, ill, inc, dec, k;
        logic [4:0] opc;
        logic       con;
        bit         got;

        f0w = '0; f0w.bus = SelPc; f0w.e_mar = 1'b1; f0w.incpc = 1'b1;
        zw = '0;
        haltw = '0; haltw.halted = 1'b1;

        vecs[0] = '{OpLdi, 1'b0, 7 + L,     L,     0, 0, 0};
        vecs[1] = '{OpLd,  1'b0, 9 + 2 * L, 2 * L, 0, 0, 0};
        vecs[2] = '{OpSt,  1'b0, 8 + 2 * L, L,     L, 0, 0};
        vecs[3] = '{OpAdd, 1'b1, 7 + L,     L,     0, 0, 0};
        vecs[4] = '{OpBr,  1'b1, 8 + L,     L,     0, 1, 0};
        vecs[5] = '{OpBr,  1'b0, 8 + L,     L,     0, 0, 0};
        vecs[6] = '{OpNop, 1'b0, 5 + L,     L,     0, 0, 0};
        vecs[7] = '{OpIll, 1'b0, 5 + L,     L,     0, 0, 1};
        vecs[8] = '{5'b00111, 1'b1, 5 + L,  L,     0, 0, 1};

        clear = 1'b1;
        sif.run = 1'b0; sif.opcode = OpNop; sif.con_ff = 1'b0;
`ifdef SRC_SEQ_STEP_EN
        step = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        check_obs("reset outputs", zw);
        clear = 1'b0;
        sif.run = 1'b1;

`ifdef SRC_SEQ_STEP_EN
        run_instr(OpNop, 1'b0, cyc, rd, wr, epc, ill, inc);
        check_int("step first nop cycles", cyc, 5 + L);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check_obs($sformatf("step parked %0d", i), zw);
        end
        step = 1'b1;
        @(posedge clock); #1;
        check_obs("step release f0", f0w);
        cyc = 1; got = 1'b0;
        while (!got && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
            got = sif.instr_done;
        end
        check_int("step second nop cycles", cyc, 5 + L);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check_obs($sformatf("step held parked %0d", i), zw);
        end
        step = 1'b0;
        @(posedge clock); #1;
        step = 1'b1;
        @(posedge clock); #1;
        check_obs("step re-release f0", f0w);
        step = 1'b0;
        clear = 1'b1;
        @(posedge clock); #1;
        check_obs("step clear", zw);
        clear = 1'b0;
        sif.run = 1'b0;
`else
        foreach (vecs[v]) begin
            run_instr(vecs[v].opc, vecs[v].con, cyc, rd, wr, epc, ill, inc);
            check_int($sformatf("vec%0d cycles", v), cyc, vecs[v].cycles);
            check_int($sformatf("vec%0d ram_read", v), rd, vecs[v].reads);
            check_int($sformatf("vec%0d ram_write", v), wr, vecs[v].writes);
            check_int($sformatf("vec%0d e_PC", v), epc, vecs[v].epc);
            check_int($sformatf("vec%0d illegal", v), ill, vecs[v].ill);
            check_int($sformatf("vec%0d incPC", v), inc, 1);
        end

        // Opcode is scrambled everywhere except DEC; con_ff is held from DEC to the end.
        sif.opcode = 5'($urandom);
        sif.con_ff = 1'($urandom);
        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: opc = OpLd;   1: opc = OpLdi; 2: opc = OpSt; 3: opc = OpAdd;
                4: opc = OpBr;   5: opc = OpNop; default: opc = 5'($urandom);
            endcase
            if (opc == OpHalt) opc = OpIll;
            con = 1'($urandom);
            build(opc, con, dec);
            for (int i = 0; i < trace.size(); i++) begin
                @(posedge clock); #1;
                check_obs($sformatf("rand n%0d op%b con%0b t%0d", n, opc, con, i), trace[i]);
                sif.opcode = (i == dec) ? opc : 5'($urandom);
                sif.con_ff = (i >= dec) ? con : 1'($urandom);
            end
        end

        sif.opcode = OpAdd;
        @(posedge clock); #1;
        check_obs("run drop f0", f0w);
        sif.run = 1'b0;
        cyc = 1; got = 1'b0;
        while (!got && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
            got = sif.instr_done;
        end
        check_int("run drop add cycles", cyc, 7 + L);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check_obs($sformatf("run drop idle %0d", i), zw);
        end
`endif

        sif.opcode = OpLd;
        sif.run = 1'b1;
        for (int c = 1; c <= 8 + L; c++) begin
            @(posedge clock); #1;
        end
        check_int("ld e3 ram_read", int'(sif.ram_read), 1);
        clear = 1'b1;
        @(posedge clock); #1;
        check_obs("clear mid ld e3", zw);
        clear = 1'b0;
        @(posedge clock); #1;
        check_obs("f0 after clear", f0w);

        sif.opcode = OpHalt;
        repeat (L + 3) @(posedge clock);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            check_obs($sformatf("halted %0d", i), haltw);
            sif.opcode = 5'($urandom);
            sif.run = 1'($urandom);
        end
        clear = 1'b1;
        sif.run = 1'b0;
        @(posedge clock); #1;
        check_obs("clear from halt", zw);
        clear = 1'b0;
        @(posedge clock); #1;
        check_obs("idle after halt clear", zw);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
